// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues requests to a 1-cycle-latency
// instruction SRAM and hands {pc, inst} to decode. The instruction word is
// parked in a local buffer while decode stalls, and decode redirects flush
// any wrong-path fetch.
//
// Handshake (fetch -> decode): an instruction transfers on a cycle where
// to_ds_valid and ds_allow_in are both 1. to_ds_valid never depends on
// ds_allow_in. A redirect (br_taken_cancel) overrides the handshake: the
// instruction in fetch is dropped and to_ds_valid is forced low.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allow_in,
  input  logic        br_taken_cancel,
  input  logic [31:0] br_target,
  output logic        to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;

  logic        fs_ready_go;
  logic        fs_allow_in;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;

  // The SRAM answers in a fixed single cycle, so fetch is always ready.
  assign fs_ready_go = 1'b1;

  // Next-PC selection, acceptance and stall-buffer update.
  always_comb begin
    seq_pc           = fs_pc_q + 32'd4;
    nextpc           = br_taken_cancel ? br_target : seq_pc;
    fs_allow_in      = !fs_valid_q || (fs_ready_go && ds_allow_in) || br_taken_cancel;

    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;

    if (fs_allow_in) begin
      // A new request replaces whatever sat in fetch, buffered or not.
      fs_valid_d       = 1'b1;
      fs_pc_d          = nextpc;
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q && !ds_allow_in && !br_taken_cancel && !inst_buf_valid_q) begin
      // First stall cycle: the SRAM data is only valid now, so capture it.
      inst_buf_d       = inst_sram_rdata;
      inst_buf_valid_d = 1'b1;
    end
  end

  // Fetch state registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_q       <= 32'h0;
      inst_buf_valid_q <= 1'b0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
    end
  end

  // SRAM request and decode-facing outputs; reset forces quiet values at once.
  always_comb begin
    inst_sram_en    = !reset && fs_allow_in;
    inst_sram_we    = 4'h0;
    inst_sram_wdata = 32'h0;
    inst_sram_addr  = reset ? RESET_PC : nextpc;
    to_ds_valid     = fs_valid_q && fs_ready_go && !br_taken_cancel;
    fs_pc           = fs_pc_q;
    fs_inst         = reset ? 32'h0 : (inst_buf_valid_q ? inst_buf_q : inst_sram_rdata);
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed walk through fetch/stall/redirect/reset
// scenarios followed by randomized traffic, checked against a PC-level model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allow_in;
  logic        br_taken_cancel;
  logic [31:0] br_target;
  logic        to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .ds_allow_in(ds_allow_in), .br_taken_cancel(br_taken_cancel), .br_target(br_target),
    .to_ds_valid(to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents as seen by the fetch stage.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  // ---------------- reference model ----------------
  // The model only knows "which PC is sitting in fetch, if any". Its
  // instruction is always mem_word(pc), however many cycles it has waited.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [63:0] exp_q[$];   // {pc, inst} expected at each decode transfer

  // Values sampled from the DUT mid-cycle for directed checks.
  logic        obs_valid, obs_en;
  logic [31:0] obs_pc, obs_inst, obs_addr;

  // SRAM request seen this cycle; answered in the next cycle only.
  logic        req_pending;
  logic [31:0] req_addr;

  task automatic model_reset();
    m_valid     = 1'b0;
    m_pc        = RESET_PC - 32'd4;
    req_pending = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at the following posedge+1.
  task automatic cyc(input logic allow, input logic cancel, input logic [31:0] target);
    logic        e_en;
    logic [31:0] e_addr;
    logic [63:0] item;
    ds_allow_in     = allow;
    br_taken_cancel = cancel;
    br_target       = target;
    @(negedge clk);
    obs_valid = to_ds_valid;
    obs_en    = inst_sram_en;
    obs_addr  = inst_sram_addr;
    obs_pc    = fs_pc;
    obs_inst  = fs_inst;

    e_en   = !m_valid || allow || cancel;
    e_addr = cancel ? target : m_pc + 32'd4;
    chk("to_ds_valid", {31'd0, obs_valid}, {31'd0, m_valid && !cancel});
    chk("sram_en", {31'd0, obs_en}, {31'd0, e_en});
    if (e_en) chk("sram_addr", obs_addr, e_addr);
    chk("sram_we", {28'd0, inst_sram_we}, 32'd0);
    chk("sram_wdata", inst_sram_wdata, 32'd0);
    if (m_valid) begin
      chk("fs_pc", obs_pc, m_pc);
      chk("fs_inst", obs_inst, mem_word(m_pc));
    end

    // Scoreboard: model predicts transfers, DUT transfers consume them.
    if (m_valid && !cancel && allow) exp_q.push_back({m_pc, mem_word(m_pc)});
    if (obs_valid && allow) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_xfer", obs_pc, 32'hffffffff);
      end else begin
        item = exp_q.pop_front();
        chk("sb_pc", obs_pc, item[63:32]);
        chk("sb_inst", obs_inst, item[31:0]);
      end
    end

    req_pending = inst_sram_en;
    req_addr    = inst_sram_addr;

    @(posedge clk);
    if (e_en) begin
      m_valid = 1'b1;
      m_pc    = e_addr;
    end
    #1;
    // Data is only meaningful in the cycle right after a request.
    inst_sram_rdata = req_pending ? mem_word(req_addr) : $urandom;
  endtask

  // Asynchronous reset pulse between edges; called at posedge+1.
  task automatic mid_reset();
    ds_allow_in     = 1'b1;
    br_taken_cancel = 1'b1;
    br_target       = 32'hdeadbeec;
    #2 reset = 1'b1;
    #1;
    chk("rst_to_ds_valid", {31'd0, to_ds_valid}, 32'd0);
    chk("rst_sram_en", {31'd0, inst_sram_en}, 32'd0);
    chk("rst_sram_addr", inst_sram_addr, RESET_PC);
    chk("rst_fs_pc", fs_pc, RESET_PC - 32'd4);
    chk("rst_fs_inst", fs_inst, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    inst_sram_rdata = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    ds_allow_in     = 1'b1;
    br_taken_cancel = 1'b1;
    br_target       = 32'h12345678;
    inst_sram_rdata = 32'h5a5a5a5a;
    model_reset();
    @(negedge clk);
    chk("rst_to_ds_valid", {31'd0, to_ds_valid}, 32'd0);
    chk("rst_sram_en", {31'd0, inst_sram_en}, 32'd0);
    chk("rst_sram_addr", inst_sram_addr, RESET_PC);
    chk("rst_fs_pc", fs_pc, RESET_PC - 32'd4);
    chk("rst_fs_inst", fs_inst, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First fetch after release.
    cyc(1'b1, 1'b0, 32'd0);
    chk("first_req_en", {31'd0, obs_en}, 32'd1);
    chk("first_req_addr", obs_addr, 32'h1c000000);
    cyc(1'b1, 1'b0, 32'd0);
    chk("first_valid", {31'd0, obs_valid}, 32'd1);
    chk("first_pc", obs_pc, 32'h1c000000);
    chk("first_inst", obs_inst, 32'hb9a5a5a5);
    cyc(1'b1, 1'b0, 32'd0);
    chk("seq_pc1", obs_pc, 32'h1c000004);

    // Stall three cycles on 1c000008.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'd0);
      chk("stall_pc", obs_pc, 32'h1c000008);
      chk("stall_inst", obs_inst, 32'hb9a5a5ad);
      chk("stall_en", {31'd0, obs_en}, 32'd0);
    end
    cyc(1'b1, 1'b0, 32'd0);
    chk("stall_release_pc", obs_pc, 32'h1c000008);
    cyc(1'b1, 1'b0, 32'd0);
    chk("after_stall_pc", obs_pc, 32'h1c00000c);
    chk("after_stall_inst", obs_inst, 32'hb9a5a5a9);

    // Single-cycle redirect from 1c000010.
    cyc(1'b1, 1'b1, 32'h1c000100);
    chk("redir_pc_at", obs_pc, 32'h1c000010);
    chk("redir_valid", {31'd0, obs_valid}, 32'd0);
    chk("redir_addr", obs_addr, 32'h1c000100);
    cyc(1'b1, 1'b0, 32'd0);
    chk("redir_tgt_pc", obs_pc, 32'h1c000100);
    chk("redir_tgt_valid", {31'd0, obs_valid}, 32'd1);

    // Redirect while an instruction is buffered under stall.
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 32'h1c000200);
    chk("stall_redir_valid", {31'd0, obs_valid}, 32'd0);
    chk("stall_redir_addr", obs_addr, 32'h1c000200);
    cyc(1'b1, 1'b0, 32'd0);
    chk("stall_redir_pc", obs_pc, 32'h1c000200);
    chk("stall_redir_inst", obs_inst, mem_word(32'h1c000200));

    // Redirect held three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 32'h1c000300);
      chk("multi_redir_addr", obs_addr, 32'h1c000300);
      chk("multi_redir_valid", {31'd0, obs_valid}, 32'd0);
    end
    cyc(1'b1, 1'b0, 32'd0);
    chk("multi_redir_pc", obs_pc, 32'h1c000300);
    cyc(1'b1, 1'b0, 32'd0);
    chk("multi_redir_next", obs_pc, 32'h1c000304);

    // Reset pulse in the middle of a stall.
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    mid_reset();
    cyc(1'b1, 1'b0, 32'd0);
    chk("rerst_req_addr", obs_addr, 32'h1c000000);
    cyc(1'b1, 1'b0, 32'd0);
    chk("rerst_pc", obs_pc, 32'h1c000000);
    chk("rerst_inst", obs_inst, 32'hb9a5a5a5);

    // Address wrap at the top of memory.
    cyc(1'b1, 1'b1, 32'hfffffff8);
    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    chk("wrap_pc", obs_pc, 32'hfffffffc);
    cyc(1'b1, 1'b0, 32'd0);
    chk("wrap_zero", obs_pc, 32'h00000000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        a, c;
      logic [31:0] t;
      a = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 3))
        0:       t = 32'hfffffff8;
        1:       t = $urandom;                       // possibly misaligned
        default: t = {$urandom_range(0, 32'h3fffffff), 2'b00};
      endcase
      if ($urandom_range(0, 199) == 0) mid_reset();
      else cyc(a, c, t);
    end

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
